four_bit_mux_arbiter: RTL and testbench
=======================================

# four_bit_mux_arbiter

Four-channel 4-bit collector: the merging counterpart of the 1-to-4 demux that fans one signal out to channels A–D. It accepts words from four independent valid/ready sources and grants them in round-robin order. It forwards each granted word through a single registered output channel, tagged with the 2-bit `Select` of its source. It sits upstream of any single consumer that must serve the four demux-side channels fairly.

## Interface
- `WIDTH`, default 4: data width of every channel.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `Enable`  input  1  arbitration enable; low blocks new grants only.
- `A`, `B`, `C`, `D`  input  WIDTH  channel 0–3 data.
- `A_valid`, `B_valid`, `C_valid`, `D_valid`  input  1  channel 0–3 request.
- `A_ready`, `B_ready`, `C_ready`, `D_ready`  output  1  channel 0–3 grant (combinational).
- `Signal`  output  WIDTH  registered output data.
- `Select`  output  2  registered source tag: 0=A, 1=B, 2=C, 3=D.
- `Out_valid`  output  1  `Signal`/`Select` hold a word.
- `Out_ready`  input  1  downstream accepts the word.
- `Grants`  output  8  saturating transfer count; present only with `MUX_STATS_EN`.

## Operation
- One output holding register, with fields `Signal`, `Select` and `Out_valid`.
- Round-robin pointer `Last` (2 bits) records the most recently granted channel.
- Input transfer on a channel happens when `X_valid && X_ready`. Output transfer happens when `Out_valid && Out_ready`.
- `load` = `Enable && (any X_valid) && (!Out_valid || Out_ready)`.
- When `load` is 1, exactly one `X_ready` is high: the first valid channel in the search order `Last+1, Last+2, Last+3, Last` (mod 4). All other `X_ready` are 0.
- When `load` is 0, all `X_ready` are 0.
- A `load` captures the granted data into `Signal`, the channel index into `Select`, and sets `Out_valid`=1. It also sets `Last` to the granted index.
- An output transfer without a `load` clears `Out_valid`. `Signal` and `Select` keep their stale values.
- A simultaneous output transfer and `load` replaces the word, and `Out_valid` stays 1.
- `Enable`=0 freezes arbitration and `Last`. A word already held still drains via `Out_ready`.
- Source data is not inspected. Zero-valued words are legal and transfer normally.
- `X_ready` never depends on `X_valid` of the same channel alone. It depends on all valids, `Enable`, `Out_valid`, `Out_ready` and `Last`, with no combinational loop through `X_ready`.

## Timing
- Reset values:
  - `Out_valid`=0, `Signal`=0, `Select`=0.
  - `Last`=3, so channel A wins first.
  - `Grants`=0.
  - All `X_ready`=0 while `reset` is high.
- Reset asserted mid-operation discards the held word immediately, without waiting for a clock edge.
- Latency: input transfer at edge N sets `Out_valid` high and presents the word after edge N.
- Throughput: one word per cycle while `Out_ready` stays 1.
- Fairness: with all four channels valid continuously and `Out_ready`=1, grants cycle A,B,C,D,A,… and no channel waits more than 3 grants.
- Backpressure: with `Out_valid`=1 and `Out_ready`=0, all `X_ready`=0 and the output word is held stable.
- A source that drops `X_valid` without being granted loses nothing. The block never captures ungranted data.

## Configuration
- Macro `MUX_STATS_EN`.
- Defined:
  - Port `Grants` [7:0] exists.
  - `Grants` increments on every output transfer and saturates at 255.
  - `Grants` clears to 0 on `reset`.
- Undefined:
  - Port `Grants` and its counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset release, `Enable`=1, only `B_valid`=1 with B=4'h5, `Out_ready`=1 → `B_ready`=1 in the first cycle. The next cycle shows `Signal`=5, `Select`=1, `Out_valid`=1.
- All four valid with A=1, B=2, C=3, D=4 held, `Out_ready`=1 for 8 cycles → `Select` sequence 0,1,2,3,0,1,2,3 and `Signal` sequence 1,2,3,4,1,2,3,4.
- Word held and `Out_ready`=0 for 5 cycles with all sources valid → all `X_ready`=0. `Signal` and `Select` stay unchanged, then the word drains the cycle `Out_ready` rises.
- `Enable`=0 with A valid and the output register empty → `A_ready`=0 and `Out_valid` stays 0. Raising `Enable` grants A within 1 cycle.
- Assert `reset` asynchronously mid-stream with `Out_valid`=1 → `Out_valid`=0 before the next edge. After release with A,C valid, the first grant goes to A.
- With `MUX_STATS_EN`: 300 output transfers → `Grants`=255. A `reset` pulse → `Grants`=0.

Source files
------------

// File: rtl/four_bit_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_mux_arbiter
// Purpose  : Four-channel valid/ready collector. Grants one source per cycle
//            in round-robin order and forwards the word through a single
//            registered output slot, tagged with the 2-bit source index.
// Options  : `define MUX_STATS_EN adds the 8-bit saturating Grants counter,
//            which counts output transfers.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             A_valid,
  input  logic             B_valid,
  input  logic             C_valid,
  input  logic             D_valid,
  output logic             A_ready,
  output logic             B_ready,
  output logic             C_ready,
  output logic             D_ready,
  output logic [WIDTH-1:0] Signal,
  output logic [1:0]       Select,
  input  logic             Out_ready,
`ifdef MUX_STATS_EN
  output logic [7:0]       Grants,
`endif
  output logic             Out_valid
);

  // After reset the pointer sits on D, so channel A is searched first.
  localparam logic [1:0] LAST_RST = 2'd3;

  logic [3:0]       w_valid;
  logic [1:0]       w_grant_idx;
  logic             w_found;
  logic             w_load;
  logic [WIDTH-1:0] w_grant_data;
  logic [3:0]       w_ready;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] signal_q,    signal_d;
  logic [1:0]       select_q,    select_d;
  logic [1:0]       last_q,      last_d;

  assign w_valid = {D_valid, C_valid, B_valid, A_valid};

  // Round-robin search: first valid channel starting just after the last grant.
  always_comb begin
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_valid[last_q + 2'(k)]) begin
        w_grant_idx = last_q + 2'(k);
        w_found     = 1'b1;
      end
    end
  end

  // A new word may enter when the slot is empty or being drained this cycle.
  // Reset is folded in so no grant is ever shown while reset is asserted.
  assign w_load = !reset && Enable && w_found && (!out_valid_q || Out_ready);

  // One-hot grant; all ready lines stay low whenever no load happens.
  always_comb begin
    w_ready = 4'b0000;
    if (w_load) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign A_ready = w_ready[0];
  assign B_ready = w_ready[1];
  assign C_ready = w_ready[2];
  assign D_ready = w_ready[3];

  // Data of the granted channel.
  always_comb begin
    w_grant_data = A;
    case (w_grant_idx)
      2'd0:    w_grant_data = A;
      2'd1:    w_grant_data = B;
      2'd2:    w_grant_data = C;
      default: w_grant_data = D;
    endcase
  end

  // Next state of the output slot and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    signal_d    = signal_q;
    select_d    = select_q;
    last_d      = last_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      signal_d    = w_grant_data;
      select_d    = w_grant_idx;
      last_d      = w_grant_idx;
    end else if (out_valid_q && Out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and pointer registers; reset discards any held word at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      signal_q    <= '0;
      select_q    <= 2'd0;
      last_q      <= LAST_RST;
    end else begin
      out_valid_q <= out_valid_d;
      signal_q    <= signal_d;
      select_q    <= select_d;
      last_q      <= last_d;
    end
  end

  assign Out_valid = out_valid_q;
  assign Signal    = signal_q;
  assign Select    = select_q;

`ifdef MUX_STATS_EN
  logic [7:0] grants_q, grants_d;

  // Count output transfers, sticking at 255.
  always_comb begin
    grants_d = grants_q;
    if (out_valid_q && Out_ready && (grants_q != 8'hFF)) begin
      grants_d = grants_q + 8'd1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= 8'd0;
    end else begin
      grants_q <= grants_d;
    end
  end

  assign Grants = grants_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_four_bit_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_bit_mux_arbiter
// Purpose  : Self-checking bench for four_bit_mux_arbiter: directed scenarios
//            followed by random traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_four_bit_mux_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] din [4];
  logic [3:0]       vin;
  logic             ordy;

  logic             a_rdy, b_rdy, c_rdy, d_rdy;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] sig;
  logic [1:0]       sel;
  logic             ov;
`ifdef MUX_STATS_EN
  logic [7:0]       grants;
`endif

  assign rdy = {d_rdy, c_rdy, b_rdy, a_rdy};

  four_bit_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .Enable    (en),
    .A         (din[0]),
    .B         (din[1]),
    .C         (din[2]),
    .D         (din[3]),
    .A_valid   (vin[0]),
    .B_valid   (vin[1]),
    .C_valid   (vin[2]),
    .D_valid   (vin[3]),
    .A_ready   (a_rdy),
    .B_ready   (b_rdy),
    .C_ready   (c_rdy),
    .D_ready   (d_rdy),
    .Signal    (sig),
    .Select    (sel),
    .Out_ready (ordy),
`ifdef MUX_STATS_EN
    .Grants    (grants),
`endif
    .Out_valid (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the last granted channel and the held word.
  int m_last;
  bit m_valid;
  int m_sig;
  int m_sel;
  int m_grants;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_last   = 3;
    m_valid  = 1'b0;
    m_sig    = 0;
    m_sel    = 0;
    m_grants = 0;
  endfunction

  // Channel that would win now, or -1 if no word may enter this cycle.
  function automatic int model_winner();
    if (reset || !en || vin == 4'b0000 || (m_valid && !ordy)) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (vin[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_ready();
    int w;
    w = model_winner();
    return (w < 0) ? 0 : (1 << w);
  endfunction

  // Advance the model by one clock edge with the inputs currently applied.
  function automatic void model_step();
    int  w;
    bit  drained;
    w       = model_winner();
    drained = m_valid && ordy;
    if (drained && m_grants < 255) m_grants++;
    if (w >= 0) begin
      m_valid = 1'b1;
      m_sig   = int'(din[w]);
      m_sel   = w;
      m_last  = w;
    end else if (drained) begin
      m_valid = 1'b0;
    end
  endfunction

  // One clock: entered and left 1 time unit after a rising edge.
  task automatic cycle();
    #4;
    chk("ready", rdy, model_ready());
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", ov, m_valid);
    chk("signal", sig, m_sig);
    chk("select", sel, m_sel);
`ifdef MUX_STATS_EN
    chk("grants", grants, m_grants);
`endif
  endtask

  // Asynchronous reset pulse starting between edges.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_out_valid", ov, 0);
    chk("arst_ready", rdy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    vin   = 4'b0001;
    ordy  = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    model_reset();

    // Reset state, with a request pending that must not be granted.
    #3;
    chk("rst_ready", rdy, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_signal", sig, 0);
    chk("rst_select", sel, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vin   = 4'b0000;

    // Single source B.
    vin = 4'b0010; din[1] = 4'h5; ordy = 1'b1;
    cycle();
    chk("b_only_signal", sig, 5);
    chk("b_only_select", sel, 1);

    // All four valid: strict A,B,C,D rotation from a fresh reset.
    do_reset();
    vin = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = 4'(i + 1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_select", sel, i % 4);
      chk("rr_signal", sig, (i % 4) + 1);
    end

    // Backpressure: word held for 5 cycles, then drained.
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_select", sel, 3);
    end
    ordy = 1'b1;
    vin  = 4'b0000;
    cycle();
    chk("bp_drained", ov, 0);

    // Enable low blocks grants; raising it grants A.
    en = 1'b0; vin = 4'b0001; din[0] = 4'h0;
    cycle();
    cycle();
    chk("en_off_valid", ov, 0);
    en = 1'b1;
    cycle();
    chk("en_on_select", sel, 0);
    chk("en_on_zero_word", ov, 1);

    // Asynchronous reset mid-stream, then A and C compete.
    vin = 4'b1111;
    cycle();
    cycle();
    do_reset();
    vin = 4'b0101; din[0] = 4'h9; din[2] = 4'h6;
    cycle();
    chk("post_rst_first", sel, 0);
    cycle();
    chk("post_rst_second", sel, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      vin  = 4'($urandom);
      for (int j = 0; j < 4; j++) din[j] = WIDTH'($urandom);
      en   = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 7);
      cycle();
    end

`ifdef MUX_STATS_EN
    // Counter saturation and clear.
    do_reset();
    en = 1'b1; vin = 4'b1111; ordy = 1'b1;
    for (int i = 0; i < 301; i++) cycle();
    chk("grants_sat", grants, 255);
    do_reset();
    chk("grants_clear", grants, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
